// File: rtl/cpu_pkg.sv
// Shared CPU definitions: load access modes, default datapath width and field sizes.
// Also holds the state type for the load-extender output buffer.
package cpu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam int BYTE_BITS  = 8;
  localparam int HALF_BITS  = 16;
  localparam int WORD_BITS  = 32;
  localparam int DWORD_BITS = 64;

  typedef enum logic [2:0] {
    LB   = 3'b000,
    LH   = 3'b001,
    LW   = 3'b010,
    LD   = 3'b011,
    LBU  = 3'b100,
    LHU  = 3'b101,
    LWU  = 3'b110,
    RSVD = 3'b111
  } load_mode_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'b00,
    BUF_ONE   = 2'b01,
    BUF_FULL  = 2'b11
  } buf_state_e;

endpackage

// File: rtl/load_ext_core.sv
// Combinational load-data select and extend: picks the addressed field out of the
// memory word, sign- or zero-extends it, and flags misaligned or illegal accesses.
module load_ext_core
  import cpu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      addr,
  input  logic [2:0]      mode,
  output logic [XLEN-1:0] result,
  output logic            err
);

  load_mode_e      modeE;
  logic [2:0]      off;
  logic [6:0]      fieldBits;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] lowMask;
  logic [XLEN-1:0] fill;
  logic            signBit;
  logic            misaligned;
  logic            illegal;

  always_comb begin
    modeE   = load_mode_e'(mode);
    off     = (XLEN == 64) ? addr : {1'b0, addr[1:0]};
    shifted = data >> {off, 3'b000};

    unique case (mode[1:0])
      2'd0:    fieldBits = 7'(BYTE_BITS);
      2'd1:    fieldBits = 7'(HALF_BITS);
      2'd2:    fieldBits = 7'(WORD_BITS);
      default: fieldBits = 7'(DWORD_BITS);
    endcase

    // A shift by >= XLEN yields zero, so word-at-XLEN32 and LD both get an all-ones mask.
    lowMask = ~({XLEN{1'b1}} << fieldBits);
    signBit = !mode[2] && (|(shifted & (lowMask ^ (lowMask >> 1))));
    fill    = signBit ? ~lowMask : '0;

    unique case (mode[1:0])
      2'd1:    misaligned = off[0];
      2'd2:    misaligned = |off[1:0];
      2'd3:    misaligned = |off;
      default: misaligned = 1'b0;
    endcase

    illegal = (modeE == RSVD) || ((XLEN == 32) && ((modeE == LD) || (modeE == LWU)));
    err     = misaligned || illegal;
    result  = err ? '0 : ((shifted & lowMask) | fill);
  end

endmodule

// File: rtl/load_ext_unit.sv
// Registered load-data extender with a 2-entry skid buffer on the output side.
// in_ready depends only on the buffer state register, never on out_ready.
//
//   state     | meaning
//   BUF_EMPTY | nothing held, out_valid=0
//   BUF_ONE   | main entry valid, skid empty
//   BUF_FULL  | main and skid valid, input stalled
module load_ext_unit
  import cpu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_data,
  input  logic [2:0]      in_addr,
  input  logic [2:0]      in_mode,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            out_err,
  output logic [TAGW-1:0] out_tag
);

  buf_state_e      state;
  buf_state_e      stateNext;
  logic            accept;
  logic            outXfer;
  logic            loadMain;
  logic            loadSkid;
  logic            moveSkid;

  logic [XLEN-1:0] extData;
  logic            extErr;

  logic [XLEN-1:0] mainData;
  logic            mainErr;
  logic [TAGW-1:0] mainTag;
  logic [XLEN-1:0] skidData;
  logic            skidErr;
  logic [TAGW-1:0] skidTag;

  load_ext_core #(.XLEN(XLEN)) uCore (
    .data   (in_data),
    .addr   (in_addr),
    .mode   (in_mode),
    .result (extData),
    .err    (extErr)
  );

  assign in_ready  = (state != BUF_FULL);
  assign out_valid = (state != BUF_EMPTY);
  assign out_data  = mainData;
  assign out_err   = mainErr;
  assign out_tag   = mainTag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BUF_EMPTY;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    loadMain  = 1'b0;
    loadSkid  = 1'b0;
    moveSkid  = 1'b0;
    accept    = in_valid && (state != BUF_FULL);
    outXfer   = (state != BUF_EMPTY) && out_ready;

    if (flush) begin
      stateNext = BUF_EMPTY;
    end else begin
      unique case (state)
        BUF_EMPTY: begin
          if (accept) begin
            loadMain  = 1'b1;
            stateNext = BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (accept && outXfer) begin
            loadMain = 1'b1;
          end else if (accept) begin
            loadSkid  = 1'b1;
            stateNext = BUF_FULL;
          end else if (outXfer) begin
            stateNext = BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          if (outXfer) begin
            moveSkid  = 1'b1;
            stateNext = BUF_ONE;
          end
        end
        default: stateNext = BUF_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mainData <= '0;
      mainErr  <= 1'b0;
      mainTag  <= '0;
      skidData <= '0;
      skidErr  <= 1'b0;
      skidTag  <= '0;
    end else begin
      if (loadMain) begin
        mainData <= extData;
        mainErr  <= extErr;
        mainTag  <= in_tag;
      end else if (moveSkid) begin
        mainData <= skidData;
        mainErr  <= skidErr;
        mainTag  <= skidTag;
      end
      if (loadSkid) begin
        skidData <= extData;
        skidErr  <= extErr;
        skidTag  <= in_tag;
      end
    end
  end

endmodule

// File: tb/tb_load_ext_unit.sv
// Self-checking bench for load_ext_unit: directed cases at XLEN=32/64, back-pressure,
// flush and reset, then randomized traffic against a queue-based reference model.
module tb_load_ext_unit;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        flush, inValid, inReady, outValid, outReady, outErr;
  logic [31:0] inData, outData;
  logic [2:0]  inAddr, inMode;
  logic [4:0]  inTag, outTag;

  logic        flush64, inValid64, inReady64, outValid64, outReady64, outErr64;
  logic [63:0] inData64, outData64;
  logic [2:0]  inAddr64, inMode64;
  logic [4:0]  inTag64, outTag64;

  int errCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  load_ext_unit #(.XLEN(32), .TAGW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(inValid), .in_ready(inReady), .in_data(inData),
    .in_addr(inAddr), .in_mode(inMode), .in_tag(inTag),
    .out_valid(outValid), .out_ready(outReady), .out_data(outData),
    .out_err(outErr), .out_tag(outTag)
  );

  load_ext_unit #(.XLEN(64), .TAGW(5)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush64),
    .in_valid(inValid64), .in_ready(inReady64), .in_data(inData64),
    .in_addr(inAddr64), .in_mode(inMode64), .in_tag(inTag64),
    .out_valid(outValid64), .out_ready(outReady64), .out_data(outData64),
    .out_err(outErr64), .out_tag(outTag64)
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: {err, value} computed from byte arithmetic on the raw word.
  function automatic logic [64:0] refLoad(input longint unsigned data, input int addr,
                                          input int mode, input int xlen);
    int off = (xlen == 64) ? addr : (addr % 4);
    int sizeB = 1 << (mode % 4);
    int bits = 8 * sizeB;
    longint unsigned field;
    bit bad = (mode == 7) || (xlen == 32 && (mode == 3 || mode == 6)) || (off % sizeB != 0);
    if (bad) return {1'b1, 64'd0};
    field = data >> (8 * off);
    if (bits < 64) begin
      field = field & ((64'd1 << bits) - 1);
      if (mode < 4 && ((field >> (bits - 1)) & 1) == 1) field = field | ~((64'd1 << bits) - 1);
    end
    if (xlen == 32) field = field & 64'hFFFF_FFFF;
    return {1'b0, field};
  endfunction

  task automatic apply32(input string name, input logic [31:0] d, input logic [2:0] a,
                         input logic [2:0] m, input logic [31:0] expD, input logic expE);
    @(negedge clk);
    inValid = 1'b1; inData = d; inAddr = a; inMode = m; inTag = 5'd9;
    @(negedge clk);
    inValid = 1'b0;
    checkVal({name, "_valid"}, 64'(outValid), 64'd1);
    checkVal({name, "_data"}, 64'(outData), 64'(expD));
    checkVal({name, "_err"}, 64'(outErr), 64'(expE));
  endtask

  task automatic apply64(input string name, input logic [63:0] d, input logic [2:0] a,
                         input logic [2:0] m, input logic [63:0] expD, input logic expE);
    @(negedge clk);
    inValid64 = 1'b1; inData64 = d; inAddr64 = a; inMode64 = m; inTag64 = 5'd3;
    @(negedge clk);
    inValid64 = 1'b0;
    checkVal({name, "_valid"}, 64'(outValid64), 64'd1);
    checkVal({name, "_data"}, outData64, expD);
    checkVal({name, "_err"}, 64'(outErr64), 64'(expE));
  endtask

  logic [37:0] expQ[$];
  logic [64:0] r;

  initial begin
    rst_n = 1'b0;
    flush = 0; inValid = 0; outReady = 1; inData = 0; inAddr = 0; inMode = 0; inTag = 0;
    flush64 = 0; inValid64 = 0; outReady64 = 1; inData64 = 0; inAddr64 = 0; inMode64 = 0; inTag64 = 0;
    #2;
    checkVal("rst_in_ready", 64'(inReady), 64'd1);
    checkVal("rst_out_valid", 64'(outValid), 64'd0);
    checkVal("rst_out_data", 64'(outData), 64'd0);
    checkVal("rst_out_tag", 64'(outTag), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    apply32("lb_sign", 32'h1234_80FF, 3'd1, 3'b000, 32'hFFFF_FF80, 1'b0);
    apply32("lhu_zero", 32'h8001_0000, 3'd2, 3'b101, 32'h0000_8001, 1'b0);
    apply32("lh_sign", 32'h8001_0000, 3'd2, 3'b001, 32'hFFFF_8001, 1'b0);
    apply32("lw_misal", 32'hDEAD_BEEF, 3'd2, 3'b010, 32'h0, 1'b1);
    apply32("ld_illegal32", 32'hDEAD_BEEF, 3'd0, 3'b011, 32'h0, 1'b1);
    apply32("lwu_illegal32", 32'hDEAD_BEEF, 3'd0, 3'b110, 32'h0, 1'b1);
    apply32("rsvd32", 32'hDEAD_BEEF, 3'd0, 3'b111, 32'h0, 1'b1);
    apply32("lw_full", 32'h8765_4321, 3'd4, 3'b010, 32'h8765_4321, 1'b0);
    apply64("lwu64", 64'hDEAD_BEEF_0000_0000, 3'd4, 3'b110, 64'h0000_0000_DEAD_BEEF, 1'b0);
    apply64("lw64_sign", 64'hDEAD_BEEF_0000_0000, 3'd4, 3'b010, 64'hFFFF_FFFF_DEAD_BEEF, 1'b0);
    apply64("ld64", 64'h0123_4567_89AB_CDEF, 3'd0, 3'b011, 64'h0123_4567_89AB_CDEF, 1'b0);
    apply64("ld64_misal", 64'h0123_4567_89AB_CDEF, 3'd4, 3'b011, 64'h0, 1'b1);
    apply64("lb64_hi", 64'h8000_0000_0000_0000, 3'd7, 3'b000, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);

    // Back-pressure: tags 1,2 stall for two edges, tag 3 waits on in_ready.
    @(negedge clk);
    outReady = 0; inValid = 1; inData = 32'h11; inAddr = 0; inMode = 3'b100; inTag = 5'd1;
    @(negedge clk);
    inTag = 5'd2; inData = 32'h22;
    @(negedge clk);
    checkVal("bp_full_in_ready", 64'(inReady), 64'd0);
    checkVal("bp_tag1", 64'(outTag), 64'd1);
    inTag = 5'd3; inData = 32'h33; outReady = 1;
    @(negedge clk);
    checkVal("bp_ready_back", 64'(inReady), 64'd1);
    checkVal("bp_tag2", 64'(outTag), 64'd2);
    checkVal("bp_data2", 64'(outData), 64'h22);
    @(negedge clk);
    inValid = 0;
    checkVal("bp_tag3", 64'(outTag), 64'd3);
    checkVal("bp_data3", 64'(outData), 64'h33);
    @(negedge clk);
    checkVal("bp_drained", 64'(outValid), 64'd0);

    // Flush while FULL, with an input also presented in the flush cycle.
    outReady = 0; inValid = 1; inTag = 5'd4;
    repeat (2) @(negedge clk);
    checkVal("fl_full", 64'(inReady), 64'd0);
    flush = 1;
    @(negedge clk);
    flush = 0; inValid = 0; outReady = 1;
    checkVal("fl_out_valid", 64'(outValid), 64'd0);
    checkVal("fl_in_ready", 64'(inReady), 64'd1);
    @(negedge clk);
    checkVal("fl_no_replay", 64'(outValid), 64'd0);

    // Asynchronous reset mid-stream.
    outReady = 0; inValid = 1; inTag = 5'd7; inData = 32'h8000_0000; inMode = 3'b010;
    repeat (2) @(negedge clk);
    inValid = 0;
    #2 rst_n = 0;
    #1;
    checkVal("rst_mid_valid", 64'(outValid), 64'd0);
    checkVal("rst_mid_data", 64'(outData), 64'd0);
    checkVal("rst_mid_tag", 64'(outTag), 64'd0);
    checkVal("rst_mid_in_ready", 64'(inReady), 64'd1);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    checkVal("rst_no_replay", 64'(outValid), 64'd0);

    // Randomized traffic at XLEN=32 against the queue model.
    expQ.delete();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      checkVal("rnd_out_valid", 64'(outValid), 64'(expQ.size() != 0));
      checkVal("rnd_in_ready", 64'(inReady), 64'(expQ.size() < 2));
      flush    = ($urandom_range(0, 49) == 0);
      inValid  = ($urandom_range(0, 3) != 0);
      outReady = ($urandom_range(0, 2) != 0);
      inData   = $urandom;
      inAddr   = 3'($urandom_range(0, 7));
      inMode   = 3'($urandom_range(0, 7));
      inTag    = 5'($urandom_range(0, 31));
      if (flush) begin
        expQ.delete();
      end else begin
        if (outValid && outReady && expQ.size() != 0) begin
          checkVal("rnd_data", 64'(outData), 64'(expQ[0][31:0]));
          checkVal("rnd_tag", 64'(outTag), 64'(expQ[0][36:32]));
          checkVal("rnd_err", 64'(outErr), 64'(expQ[0][37]));
          void'(expQ.pop_front());
        end
        if (inValid && inReady) begin
          r = refLoad(64'(inData), int'(inAddr), int'(inMode), 32);
          expQ.push_back({r[64], inTag, r[31:0]});
        end
      end
    end
    @(negedge clk);
    flush = 0; inValid = 0;

    // Randomized single-shot checks at XLEN=64.
    for (int i = 0; i < 300; i++) begin
      logic [63:0] d;
      logic [2:0] a, m;
      d = {$urandom, $urandom};
      a = 3'($urandom_range(0, 7));
      m = 3'($urandom_range(0, 7));
      r = refLoad(d, int'(a), int'(m), 64);
      apply64("rnd64", d, a, m, r[63:0], r[64]);
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
